bus_fabric: RTL and testbench
=============================

BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 Parameter NUM_REGIONS, default 2, sets the number of slave regions (legal range 1..8).
REQ-002 Parameter ADDR_W, default 16, sets the address width.
REQ-003 Parameter DATA_W, default 8, sets the data width.
REQ-004 Parameter REGION_BASE, default {16'h1000,16'h0000}, holds packed per-region inclusive base addresses, region 0 in the LSBs.
REQ-005 Parameter REGION_LIMIT, default {16'h10FF,16'h07FF}, holds packed per-region inclusive limit addresses.
REQ-006 Parameter REGION_WAIT, default {4'd0,4'd0}, holds packed per-region wait-state counts of 0..15.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port m_addr, input, ADDR_W bits: master address, held stable from request until m_ready.
REQ-010 Port m_wdata, input, DATA_W bits: master write data.
REQ-011 Ports m_we and m_re, input, 1 bit each: master write and read requests, held until m_ready.
REQ-012 Port m_rdata, output, DATA_W bits: read data returned to the master.
REQ-013 Ports m_ready and m_err, output, 1 bit each: access-complete and access-error flags.
REQ-014 Port s_addr, output, ADDR_W bits: region-local address (m_addr minus the base of the selected region).
REQ-015 Port s_wdata, output, DATA_W bits: slave write data.
REQ-016 Ports s_we and s_re, output, NUM_REGIONS bits each: per-region write and read strobes.
REQ-017 Port s_rdata, input, NUM_REGIONS*DATA_W bits: packed slave read data (synchronous-read slaves).
REQ-018 Port err_count, output, 8 bits: count of unmapped accesses.
REQ-019 Port err_addr, output, ADDR_W bits: address of the most recent unmapped access.

Function
REQ-020 The block SHALL decode a hit when REGION_BASE[i] <= m_addr <= REGION_LIMIT[i]; on overlap, the lowest index wins.
REQ-021 The state machine SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-022 In IDLE with m_we or m_re high, the block SHALL latch the decoded region index, hit flag, and write/read type.
REQ-023 If both m_we and m_re are high, the block SHALL treat the access as a write only.
REQ-024 On a hit, the block SHALL assert s_we[i] or s_re[i] for exactly the IDLE request cycle; all other strobe bits SHALL be 0 at all times.
REQ-025 On a hit, the block SHALL load a 4-bit counter with REGION_WAIT[i], then go to RESP if the value is 0, otherwise to WAIT.
REQ-026 In WAIT, the counter SHALL decrement once per cycle, with the transition to RESP in the cycle the counter reaches 1.
REQ-027 Read latency SHALL be 1+REGION_WAIT[i] cycles from the request cycle to RESP.
REQ-028 On a miss, the block SHALL assert no strobe and go directly to RESP with the error flag set.
REQ-029 RESP SHALL last one cycle, with m_ready=1, then return to IDLE.
REQ-030 A request held high after RESP SHALL start a new access in the next IDLE cycle.
REQ-031 In RESP, m_rdata SHALL equal the s_rdata slice of the latched region for a read hit, and 0 otherwise.
REQ-032 m_rdata SHALL be 0 outside RESP.
REQ-033 m_err SHALL be 1 only in the RESP cycle of a miss.
REQ-034 On a miss, err_count SHALL increment (saturating at 8'hFF) and err_addr SHALL capture m_addr, both at the request cycle edge.
REQ-035 s_addr SHALL be computed from the currently decoded region, modulo 2^ADDR_W.
REQ-036 s_wdata SHALL pass m_wdata through combinationally.
REQ-037 When there is no hit, s_addr SHALL be m_addr.

Reset
REQ-038 While rst_n=0, the block SHALL immediately force the state to IDLE and set the counter, m_ready, m_err, m_rdata, all strobes, err_count, and err_addr to 0.
REQ-039 Reset asserted during WAIT or RESP SHALL abort the access with no m_ready pulse; after release, the held request restarts from IDLE.
REQ-040 The first request SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-041 Read hit: defaults, read of 0x0005 with region 0 returning 8'hA5 -> s_re=2'b01 for 1 cycle, s_addr=0x0005, m_ready and m_rdata=8'hA5 one cycle later.
REQ-042 IO read with REGION_WAIT={4'd3,4'd0}: read of 0x1010 -> s_re=2'b10, s_addr=0x0010, m_ready 4 cycles after the request.
REQ-043 Unmapped access: write to 0x0800 -> no strobe, m_err=1 with m_ready, err_count=1, err_addr=0x0800; 256 further misses leave err_count at 8'hFF.
REQ-044 Simultaneous strobes: m_we=m_re=1 at 0x0010 -> s_we=2'b01 only, s_re stays 0, m_rdata=0 in RESP.
REQ-045 Overlap: regions 0 and 1 both covering 0x0100 -> region 0 strobed.
REQ-046 Mid-operation reset: rst_n dropped during WAIT -> outputs 0 immediately, no m_ready; after release, the held read completes with full latency.

Source files
------------

// File: rtl/bus_fabric.sv
// bus_fabric: single-master address decoder routing accesses to NUM_REGIONS slave regions with per-region wait states and unmapped-access error tracking
module bus_fabric #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h1000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'h10FF, 16'h07FF},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = {4'd0, 4'd0}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic                          m_we,
  input  logic                          m_re,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_ready,
  output logic                          m_err,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [NUM_REGIONS-1:0]        s_we,
  output logic [NUM_REGIONS-1:0]        s_re,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
  output logic [7:0]                    err_count,
  output logic [ADDR_W-1:0]             err_addr
);
  localparam int IDX_W = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic hit_q, hit_d, rd_q, rd_d;
  logic [7:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic hit;
  logic [IDX_W-1:0] idx;
  logic [ADDR_W-1:0] base;
  logic [3:0] wait_v;
  logic req, start;
  logic [NUM_REGIONS-1:0] sel;
  // descending scan so the lowest matching index is assigned last and wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    base = '0;
    wait_v = 4'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (m_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] && m_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        base = REGION_BASE[i*ADDR_W +: ADDR_W];
        wait_v = REGION_WAIT[i*4 +: 4];
      end
  end
  assign req = m_we | m_re;
  assign start = rst_n && state_q == IDLE && req;
  assign sel = NUM_REGIONS'(1) << idx;
  assign s_we = (start && hit && m_we) ? sel : '0;
  assign s_re = (start && hit && !m_we) ? sel : '0;
  assign s_addr = hit ? m_addr - base : m_addr;
  assign s_wdata = m_wdata;
  assign m_ready = state_q == RESP;
  assign m_err = m_ready && !hit_q;
  assign m_rdata = (m_ready && hit_q && rd_q) ? s_rdata[int'(idx_q)*DATA_W +: DATA_W] : '0;
  assign err_count = err_count_q;
  assign err_addr = err_addr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    hit_d = hit_q;
    rd_d = rd_q;
    case (state_q)
      IDLE: if (req) begin
        idx_d = idx;
        hit_d = hit;
        rd_d = !m_we;
        cnt_d = hit ? wait_v : 4'd0;
        state_d = (hit && wait_v != 4'd0) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
    err_count_d = (start && !hit && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    err_addr_d = (start && !hit) ? m_addr : err_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      idx_q <= '0;
      hit_q <= 1'b0;
      rd_q <= 1'b0;
      err_count_q <= 8'd0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      rd_q <= rd_d;
      err_count_q <= err_count_d;
      err_addr_q <= err_addr_d;
    end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: scoreboard bench; stimulus queues expected responses, a negedge monitor checks them on m_ready
module tb_bus_fabric;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic m_we = 1'b0, m_re = 1'b0;
  logic [7:0] m_rdata;
  logic m_ready, m_err;
  logic [15:0] s_addr;
  logic [7:0] s_wdata;
  logic [2:0] s_we, s_re;
  logic [23:0] s_rdata;
  logic [7:0] err_count;
  logic [15:0] err_addr;
  logic [7:0] srd [3];
  bus_fabric #(
    .NUM_REGIONS(3), .ADDR_W(16), .DATA_W(8),
    .REGION_BASE({16'h00F0, 16'h1000, 16'h0000}),
    .REGION_LIMIT({16'h0110, 16'h10FF, 16'h07FF}),
    .REGION_WAIT({4'd1, 4'd3, 4'd0})
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_we(s_we), .s_re(s_re), .s_rdata(s_rdata), .err_count(err_count), .err_addr(err_addr)
  );
  // synchronous-read slaves: data is a fixed function of region and local address
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (s_re[i]) srd[i] <= s_addr[7:0] ^ 8'hA0 ^ (8'h11 * 8'(i));
  assign s_rdata = {srd[2], srd[1], srd[0]};
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [7:0] rd; logic err; int lat; int t0; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errs = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (m_ready) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_ready: m_ready with no pending access at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("rdata", m_rdata, mon_e.rd);
        chk("err", m_err, mon_e.err);
        chk("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end else begin
      chk("rdata_outside_resp", m_rdata, 0);
      chk("err_outside_resp", m_err, 0);
    end
  task automatic expect_resp(input logic [7:0] rd, input logic err, input int lat);
    exp_t e;
    e.rd = rd;
    e.err = err;
    e.lat = lat;
    e.t0 = cyc;
    q.push_back(e);
  endtask
  task automatic wait_ready();
    logic extra = 1'b0, got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      #1;
      if (s_we != 0 || s_re != 0) extra = 1'b1;
      got = m_ready;
    end
    chk("ready_seen", got, 1);
    chk("strobe_single_cycle", extra, 0);
  endtask
  task automatic access(input logic [15:0] a, input logic we, input logic re, input logic [7:0] wd,
                        input logic [2:0] ewe, input logic [2:0] ere, input logic [15:0] esa,
                        input logic [7:0] erd, input logic eerr, input int lat);
    @(negedge clk);
    m_addr = a;
    m_we = we;
    m_re = re;
    m_wdata = wd;
    expect_resp(erd, eerr, lat);
    #1;
    chk("s_we", s_we, ewe);
    chk("s_re", s_re, ere);
    chk("s_addr", s_addr, esa);
    chk("s_wdata", s_wdata, wd);
    wait_ready();
    m_we = 1'b0;
    m_re = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_m_ready", m_ready, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_m_rdata", m_rdata, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    access(16'h0005, 0, 1, 8'h00, 3'b000, 3'b001, 16'h0005, 8'hA5, 0, 1);
    access(16'h1010, 0, 1, 8'h00, 3'b000, 3'b010, 16'h0010, 8'hA1, 0, 4);
    access(16'h10FF, 0, 1, 8'h00, 3'b000, 3'b010, 16'h00FF, 8'h4E, 0, 4);
    access(16'h07FF, 0, 1, 8'h00, 3'b000, 3'b001, 16'h07FF, 8'h5F, 0, 1);
    access(16'h0100, 0, 1, 8'h00, 3'b000, 3'b001, 16'h0100, 8'hA0, 0, 1);
    access(16'h0010, 1, 1, 8'h5A, 3'b001, 3'b000, 16'h0010, 8'h00, 0, 1);
    access(16'h1020, 1, 0, 8'h33, 3'b010, 3'b000, 16'h0020, 8'h00, 0, 4);
    access(16'h0800, 1, 0, 8'h77, 3'b000, 3'b000, 16'h0800, 8'h00, 1, 1);
    chk("err_count_1", err_count, 8'd1);
    chk("err_addr_0800", err_addr, 16'h0800);
    access(16'h1100, 0, 1, 8'h00, 3'b000, 3'b000, 16'h1100, 8'h00, 1, 1);
    chk("err_count_2", err_count, 8'd2);
    chk("err_addr_1100", err_addr, 16'h1100);
    for (int i = 0; i < 256; i++)
      access(16'h2000 + 16'(i), 1, 0, 8'h00, 3'b000, 3'b000, 16'h2000 + 16'(i), 8'h00, 1, 1);
    chk("err_count_sat", err_count, 8'hFF);
    chk("err_addr_last", err_addr, 16'h20FF);
    // request held through RESP restarts in the following IDLE cycle
    @(negedge clk);
    m_addr = 16'h0007;
    m_re = 1'b1;
    expect_resp(8'hA7, 0, 1);
    wait_ready();
    @(negedge clk);
    expect_resp(8'hA7, 0, 1);
    #1 chk("held_restart_s_re", s_re, 3'b001);
    wait_ready();
    m_re = 1'b0;
    // reset during WAIT aborts, held read restarts with full latency
    @(negedge clk);
    m_addr = 16'h1010;
    m_re = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_m_ready", m_ready, 0);
    chk("abort_s_re", s_re, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_err_addr", err_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_resp(8'hA1, 0, 4);
    #1 chk("restart_s_re", s_re, 3'b010);
    wait_ready();
    m_re = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
